pre_decode_buffer: RTL

//  IFU-side instruction buffer with pre-decode. Queues fetched {pc,inst} pairs toward IDU.

---
 rtl/pre_decode_buffer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pre_decode_buffer.sv
// Instruction buffer with pre-decode, early JAL redirect and a hold on unresolved transfers.
// Optional PRE_DECODE_BTFN_EN: static backward-taken/forward-not-taken branch prediction.
module pre_decode_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [XLEN-1:0]            io_in_pc,
  input  logic [31:0]                io_in_inst,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  output logic [XLEN-1:0]            io_out_pc,
  output logic [31:0]                io_out_inst,
  output logic                       io_out_jump,
  output logic                       io_out_jal,
  output logic                       io_out_pred_taken,
  output logic                       io_redirect_valid,
  output logic [XLEN-1:0]            io_redirect_pc,
  input  logic                       io_resolve_valid,
  input  logic                       io_flush,
  output logic [$clog2(DEPTH+1)-1:0] io_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_REDIR = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;

  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [XLEN-1:0] pc_d   [DEPTH];
  logic [31:0]     inst_q [DEPTH];
  logic [31:0]     inst_d [DEPTH];
  logic [DEPTH-1:0] jump_q, jump_d;
  logic [DEPTH-1:0] jal_q, jal_d;
  logic [DEPTH-1:0] pt_q, pt_d;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            is_jal;
  logic            is_jalr;
  logic            is_br;
  logic            is_sys;
  logic [XLEN-1:0] jal_off;
`ifdef PRE_DECODE_BTFN_EN
  logic [XLEN-1:0] br_off;
`endif
  logic            dec_jump;
  logic            dec_pt;
  logic            dec_redir;
  logic [XLEN-1:0] dec_tgt;

  logic enq;
  logic deq;

  assign io_in_ready  = (state_q == S_RUN) && (count_q != CW'(DEPTH));
  assign io_out_valid = (count_q != '0);
  assign enq          = io_in_valid & io_in_ready;
  assign deq          = io_out_valid & io_out_ready;

  assign io_out_pc         = pc_q[rd_ptr_q];
  assign io_out_inst       = inst_q[rd_ptr_q];
  assign io_out_jump       = jump_q[rd_ptr_q];
  assign io_out_jal        = jal_q[rd_ptr_q];
  assign io_out_pred_taken = pt_q[rd_ptr_q];
  assign io_redirect_valid = (state_q == S_REDIR);
  assign io_redirect_pc    = redir_pc_q;
  assign io_count          = count_q;

  // Classify the incoming instruction and form its early target.
  always_comb begin
    opc     = io_in_inst[6:0];
    f3      = io_in_inst[14:12];
    is_jal  = (opc == 7'h6f);
    is_jalr = (opc == 7'h67) && (f3 == 3'd0);
    is_br   = (opc == 7'h63) && (f3 != 3'd2) && (f3 != 3'd3);
    is_sys  = (io_in_inst == 32'h0000_0073)
           || (io_in_inst == 32'h3020_0073)
           || (io_in_inst == 32'h0010_0073);
    jal_off = {{(XLEN-21){io_in_inst[31]}}, io_in_inst[31],
               io_in_inst[19:12], io_in_inst[20],
               io_in_inst[30:21], 1'b0};
    dec_tgt = io_in_pc + jal_off;
`ifdef PRE_DECODE_BTFN_EN
    br_off    = {{(XLEN-13){io_in_inst[31]}}, io_in_inst[31],
                 io_in_inst[7], io_in_inst[30:25],
                 io_in_inst[11:8], 1'b0};
    dec_pt    = is_br & io_in_inst[31];
    dec_jump  = is_jalr | is_sys;
    dec_redir = is_jal | dec_pt;
    if (dec_pt) begin
      dec_tgt = io_in_pc + br_off;
    end
`else
    dec_pt    = 1'b0;
    dec_jump  = is_jalr | is_br | is_sys;
    dec_redir = is_jal;
`endif
  end

  // Buffer storage, pointers and occupancy; flush overrides any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    jump_d   = jump_q;
    jal_d    = jal_q;
    pt_d     = pt_q;
    if (io_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        pc_d[wr_ptr_q]   = io_in_pc;
        inst_d[wr_ptr_q] = io_in_inst;
        jump_d[wr_ptr_q] = dec_jump;
        jal_d[wr_ptr_q]  = is_jal;
        pt_d[wr_ptr_q]   = dec_pt;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch-control FSM: early redirect pulse or hold until resolve.
  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    if (io_flush) begin
      state_d = S_RUN;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (enq && dec_redir) begin
            state_d    = S_REDIR;
            redir_pc_d = dec_tgt;
          end else if (enq && dec_jump) begin
            state_d = S_WAIT;
          end
        end
        S_REDIR: state_d = S_RUN;
        S_WAIT: begin
          if (io_resolve_valid) begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      redir_pc_q <= '0;
      jump_q     <= '0;
      jal_q      <= '0;
      pt_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      redir_pc_q <= redir_pc_d;
      jump_q     <= jump_d;
      jal_q      <= jal_d;
      pt_q       <= pt_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

endmodule
